// File: rtl/bcd_bin_seq_ctrl.sv
// Packed-BCD to binary converter, one digit per clock, MSD first.
// Ports: i_clk, i_rst_n (sync, active-low), i_valid/o_ready/i_bcd in,
//        o_valid/i_ready/o_bin/o_err out.
module bcd_bin_seq_ctrl #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [4*DIGITS-1:0]   i_bcd,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [BIN_W-1:0]      o_bin,
  output logic                  o_err
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [4*DIGITS-1:0] shift_reg;
  logic [BIN_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic                err;

  logic [3:0]       d;
  logic [BIN_W-1:0] acc_nx;
  logic             err_nx;
  logic             last;

  assign d      = shift_reg[4*DIGITS-1 -: 4];
  // acc*10 as two shifts and adds; wraps at BIN_W
  assign acc_nx = (acc << 3) + (acc << 1) + BIN_W'(d);
  assign err_nx = err | (d > 4'd9);
  assign last   = (cnt == LAST);

  // Reset gate keeps the source from handing over a word mid-reset
  assign o_ready = i_rst_n & (state == IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (i_valid) state_nx = CONV;
      CONV: if (last)    state_nx = DONE;
      DONE: if (i_ready) state_nx = IDLE;
      default:           state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shift_reg <= '0;
      acc       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      o_valid   <= 1'b0;
      o_bin     <= '0;
      o_err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            shift_reg <= i_bcd;
            acc       <= '0;
            cnt       <= '0;
            err       <= 1'b0;
          end
        end
        CONV: begin
          acc       <= acc_nx;
          shift_reg <= shift_reg << 4;
          cnt       <= cnt + 1'b1;
          err       <= err_nx;
          if (last) begin
            o_bin   <= err_nx ? '0 : acc_nx;
            o_err   <= err_nx;
            o_valid <= 1'b1;
          end
        end
        DONE: begin
          if (i_ready) o_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_bin_seq_ctrl.sv
// Randomized self-checking bench for bcd_bin_seq_ctrl.
// Checks DIGITS=4 and DIGITS=2 instances against a positional model.
module tb_bcd_bin_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_ready;
  logic [15:0] i_bcd;
  logic        o_ready, o_valid, o_err;
  logic [13:0] o_bin;

  logic        i_valid2, i_ready2;
  logic [7:0]  i_bcd2;
  logic        o_ready2, o_valid2, o_err2;
  logic [6:0]  o_bin2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_bin_seq_ctrl #(.DIGITS(4), .BIN_W(14)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(i_valid), .o_ready(o_ready), .i_bcd(i_bcd),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_bin(o_bin), .o_err(o_err)
  );

  bcd_bin_seq_ctrl #(.DIGITS(2), .BIN_W(7)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_valid(i_valid2), .o_ready(o_ready2), .i_bcd(i_bcd2),
    .o_valid(o_valid2), .i_ready(i_ready2),
    .o_bin(o_bin2), .o_err(o_err2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Positional value sum(d_i * 10^i); any digit > 9 forces 0 + err
  function automatic void ref_conv(input logic [31:0] bcd,
                                   input int nd,
                                   output int val,
                                   output bit err);
    int p;
    val = 0;
    err = 0;
    p   = 1;
    for (int i = 0; i < nd; i++) begin
      int dg;
      dg = int'((bcd >> (4 * i)) & 32'hF);
      if (dg > 9) err = 1;
      val += dg * p;
      p   *= 10;
    end
    if (err) val = 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic conv4(input logic [15:0] bcd,
                       input int hold,
                       input bit poke);
    int val;
    bit err;
    int n;
    ref_conv({16'h0, bcd}, 4, val, err);
    n = 0;
    while (!o_ready && n < 20) begin
      step();
      n++;
    end
    chk("ready_before_accept", o_ready, 1);
    i_bcd   = bcd;
    i_valid = 1'b1;
    i_ready = (hold == 0);
    step();
    i_valid = 1'b0;
    i_bcd   = 16'($urandom);
    n = 0;
    while (!o_valid && n < 20) begin
      chk("ready_low_busy", o_ready, 0);
      step();
      n++;
    end
    chk("latency", n, 4);
    chk("bin", o_bin, val);
    chk("err", o_err, err);
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 1) begin
        i_valid = 1'b1;
        i_bcd   = 16'h9999;
      end
      step();
      i_valid = 1'b0;
      chk("bp_valid", o_valid, 1);
      chk("bp_bin", o_bin, val);
      chk("bp_err", o_err, err);
      chk("bp_ready", o_ready, 0);
    end
    i_ready = 1'b1;
    step();
    chk("valid_drop", o_valid, 0);
    chk("ready_after_r", o_ready, 1);
    chk("bin_kept", o_bin, val);
  endtask

  initial begin
    int val;
    bit err;
    int n;
    int lat;
    logic [6:0] got;
    bit rdy;

    rst_n    = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b1;
    i_bcd    = '0;
    i_valid2 = 1'b0;
    i_ready2 = 1'b1;
    i_bcd2   = '0;

    // reset held for two edges
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_ready", o_ready, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_bin", o_bin, 0);
      chk("rst_err", o_err, 0);
    end
    rst_n = 1'b1;
    step();
    chk("ready_after_rst", o_ready, 1);

    conv4(16'h1234, 0, 0);
    conv4(16'h9999, 0, 0);
    conv4(16'h0000, 0, 0);
    conv4(16'h12A4, 0, 0);
    conv4(16'h0042, 0, 0);
    conv4(16'h0507, 6, 1);

    // reset on the second conversion cycle
    i_bcd   = 16'h8888;
    i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_bin", o_bin, 0);
    chk("mid_rst_ready", o_ready, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid_rst_no_valid", o_valid, 0);
    end
    conv4(16'h0031, 0, 0);

    // random words, some with bad digits, random back-pressure
    for (int t = 0; t < 40; t++) begin
      logic [15:0] w;
      for (int k = 0; k < 4; k++) begin
        w[4*k +: 4] = ($urandom_range(7) == 0)
                      ? 4'($urandom_range(15))
                      : 4'($urandom_range(9));
      end
      conv4(w, $urandom_range(3), $urandom_range(1));
    end

    // two-digit instance, back-to-back accepts
    i_bcd2   = 8'h59;
    i_valid2 = 1'b1;
    step();
    i_bcd2 = 8'h99;
    n   = 0;
    lat = 0;
    got = '0;
    do begin
      rdy = o_ready2;
      step();
      n++;
      if (o_valid2 && lat == 0) begin
        lat = n;
        got = o_bin2;
      end
    end while (!rdy && n < 20);
    i_valid2 = 1'b0;
    ref_conv(32'h59, 2, val, err);
    chk("d2_latency", lat, 2);
    chk("d2_bin_59", got, val);
    chk("d2_spacing", n, 4);
    n = 0;
    while (!o_valid2 && n < 20) begin
      step();
      n++;
    end
    ref_conv(32'h99, 2, val, err);
    chk("d2_latency2", n, 2);
    chk("d2_bin_99", o_bin2, val);
    chk("d2_err", o_err2, err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
